// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port LC-3 RAM.
// Serves one access at a time and returns one response pulse per grant.
`timescale 1ns/1ps
module lc3_mem_arbiter #(
   parameter int N_REQ  = 3,
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ-1:0]   req_we,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata,
   output logic               busy
);

   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW  = $clog2(RD_LAT + 1);
   localparam logic [N_REQ-1:0] ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   w_win;
   logic             w_found;
   logic             w_hs;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic [DW-1:0]    r_rdata;
   logic [CW-1:0]    r_cnt;
   logic             w_load;
   logic             w_cap;

   // Search starts one past the last grant so every requester gets a turn.
   always_comb begin : arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(r_last) + k) % N_REQ;
         if (!w_found && req_valid[IDW'(idx)]) begin
            w_found = 1'b1;
            w_win   = IDW'(idx);
         end
      end
   end

   assign req_ready = (rst_n && r_state == S_IDLE && w_found) ?
                      (ONE << w_win) : '0;
   assign w_hs      = |(req_valid & req_ready);

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      w_load    = 1'b0;
      w_cap     = 1'b0;
      rsp_valid = '0;
      rsp_rdata = '0;
      busy      = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_hs) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_en = 1'b1;
            mem_we = r_we;
            if (r_we) begin
               w_next = S_RESP;
            end else begin
               w_load = 1'b1;
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_en = 1'b1;
            if (r_cnt == CW'(1)) begin
               w_cap  = 1'b1;
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = ONE << r_id;
            rsp_rdata = r_we ? '0 : r_rdata;
            w_next    = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Payload is taken only on the handshake edge; earlier changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= IDW'(N_REQ - 1);
         r_id    <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_hs) begin
            r_id    <= w_win;
            r_last  <= w_win;
            r_we    <= req_we[w_win];
            r_addr  <= req_addr[w_win*AW +: AW];
            r_wdata <= req_wdata[w_win*DW +: DW];
         end
         if (w_load) begin
            r_cnt <= CW'(RD_LAT);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_cap) begin
            r_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Round-robin arbiter and sequencer for the single-port LC-3 RAM. It is shared by the instruction-fetch path, the load/store (MAR/MDR) path and a debug/loader port. It grants one requester at a time and drives the RAM enable, write-enable, address and write data. It waits out the fixed RAM read latency and returns one response pulse per accepted request. Only one access is outstanding at a time.

Parameters:
N_REQ, 3, number of requesters (index 0 = data path, 1 = fetch, 2 = debug)
AW, 16, address width
DW, 16, data width
RD_LAT, 2, RAM read latency in cycles (>=1); mem_rdata is sampleable RD_LAT edges after the first edge with mem_en=1, mem_we=0

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request; held with payload until its req_ready handshake
req_we  input  N_REQ  1 = write, 0 = read
req_addr  input  N_REQ*AW  packed addresses; requester i occupies [i*AW +: AW]
req_wdata  input  N_REQ*DW  packed write data
req_ready  output  N_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i] at a rising edge
rsp_valid  output  N_REQ  one-cycle one-hot completion pulse to the owning requester
rsp_rdata  output  DW  read data, valid while rsp_valid is non-zero
mem_en  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data
busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low rst_n, on clock clk. Reset forces state=IDLE, last_grant=N_REQ-1 and clears the wait counter.
- During reset all outputs are 0: req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap-around.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in all other states.
  - On the handshake edge: latch the winner's id, we, addr and wdata; set last_grant=winner; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1, mem_addr and mem_wdata from the latched values, mem_we=latched we.
  - Write: go to RESP.
  - Read: load counter=RD_LAT and go to WAIT.
- WAIT (RD_LAT cycles):
  - mem_en=1, mem_we=0, address held.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, capture mem_rdata into rsp_rdata and go to RESP.
- RESP (1 cycle):
  - rsp_valid[id]=1.
  - rsp_rdata = captured data for reads, 0 for writes.
  - Next state is IDLE unconditionally.
- Outside ISSUE and WAIT: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
- Latency is measured from the handshake edge:
  - Read: rsp_valid is asserted in cycle RD_LAT+2 (cycle 4 when RD_LAT=2).
  - Write: rsp_valid is asserted in cycle 2.
  - Minimum spacing between grants: read RD_LAT+3 cycles, write 3 cycles.
- Requests arriving while busy are held by the requester and are not lost. Changing the payload before the handshake is legal; only the handshake-edge payload is used.
- Deasserting req_valid before the handshake withdraws the request with no side effects.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,...; no requester waits more than N_REQ-1 grants.
- Simultaneous requests are resolved only by the round-robin pointer. Its reset value gives requester 0 the first grant.
- A requester may re-assert in the same cycle its rsp_valid is high. It is considered at the next IDLE.
- Reset mid-operation aborts the in-flight access immediately: no rsp_valid is produced and mem_en drops asynchronously.

Test Plan:
- Single read, RD_LAT=2: RAM[0x3000]=0x1234; requester 1 reads 0x3000 → ready in cycle 0; mem_en high for cycles 1-3 with addr 0x3000 and we=0; rsp_valid=3'b010 with rsp_rdata=0x1234 in cycle 4; busy falls in cycle 5.
- Single write: requester 0 writes 0xBEEF to 0x3001 → one cycle with mem_en=1, mem_we=1, addr 0x3001, wdata 0xBEEF; rsp_valid=3'b001 next cycle with rsp_rdata=0; a following read of 0x3001 returns 0xBEEF.
- Contention: all three requesters assert reads at once out of reset → grant order 0,1,2,0; each rsp_valid goes only to the owner; a new grant every 5 cycles.
- Hold while busy: requester 2 asserts during requester 0's WAIT → req_ready[2] stays 0 until IDLE, then the grant comes and its payload at the handshake edge is used.
- Reset mid-read: assert rst_n=0 in the WAIT state → mem_en, busy and rsp_valid are 0 immediately; after release the next grant goes to requester 0 and no stale response appears.
- Parameter sweep: RD_LAT=1 and RD_LAT=4 → read response in cycle 3 and cycle 6 after the handshake respectively, with correct data.
